// File: rtl/sop_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// Module  : sop_sweep_ctrl
// Brief   : Exhaustive 16-vector sweep checker for a 4-input SOP function.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sop_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        dut_y,
  output logic [3:0]  abcd,
  output logic        exp_y,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [4:0]  err_count,
  output logic [15:0] fail_vec,
  output logic        pass
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] c_settle_load = 4'(SETTLE_CYC - 1);

  state_t      r_state;
  logic [3:0]  r_settle_cnt;
  logic [3:0]  r_abcd;
  logic        r_busy;
  logic        r_done;
  logic        r_valid;
  logic [4:0]  r_err_count;
  logic [15:0] r_fail_vec;

  logic w_a, w_b, w_c, w_d;
  logic w_exp_y;
  logic w_mismatch;
  logic w_abort_now;

  assign w_a = r_abcd[3];
  assign w_b = r_abcd[2];
  assign w_c = r_abcd[1];
  assign w_d = r_abcd[0];

  assign w_exp_y     = (w_a & ~w_c) | (w_b & ~w_c & ~w_d) | (w_a & w_b & ~w_d);
  assign w_mismatch  = (dut_y != w_exp_y);
  assign w_abort_now = abort & ((r_state == ST_SETTLE) || (r_state == ST_SAMPLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= 4'd0;
      r_abcd       <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_valid      <= 1'b0;
      r_err_count  <= 5'd0;
      r_fail_vec   <= 16'd0;
    end else begin
      r_done <= 1'b0;
      // Abort wins over any sample taken in the same cycle.
      if (w_abort_now) begin
        r_state     <= ST_IDLE;
        r_abcd      <= 4'd0;
        r_busy      <= 1'b0;
        r_valid     <= 1'b0;
        r_err_count <= 5'd0;
        r_fail_vec  <= 16'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state      <= ST_SETTLE;
              r_abcd       <= 4'd0;
              r_err_count  <= 5'd0;
              r_fail_vec   <= 16'd0;
              r_valid      <= 1'b0;
              r_busy       <= 1'b1;
              r_settle_cnt <= c_settle_load;
            end
          end
          ST_SETTLE: begin
            if (r_settle_cnt == 4'd0) begin
              r_state <= ST_SAMPLE;
            end else begin
              r_settle_cnt <= r_settle_cnt - 4'd1;
            end
          end
          ST_SAMPLE: begin
            if (w_mismatch) begin
              r_err_count        <= r_err_count + 5'd1;
              r_fail_vec[r_abcd] <= 1'b1;
            end
            if (r_abcd == 4'd15) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_abcd       <= r_abcd + 4'd1;
              r_settle_cnt <= c_settle_load;
              r_state      <= ST_SETTLE;
            end
          end
          ST_DONE: begin
            r_valid <= 1'b1;
            r_abcd  <= 4'd0;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign abcd      = r_abcd;
  assign exp_y     = w_exp_y;
  assign busy      = r_busy;
  assign done      = r_done;
  assign valid     = r_valid;
  assign err_count = r_err_count;
  assign fail_vec  = r_fail_vec;
  assign pass      = r_valid & (r_err_count == 5'd0);

endmodule

`default_nettype wire

// File: tb/tb_sop_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// Module  : tb_sop_sweep_ctrl
// Brief   : Directed scoreboard bench for sop_sweep_ctrl (SETTLE_CYC 1 and 3).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sop_sweep_ctrl;

  typedef struct packed {
    logic [4:0]  err;
    logic [15:0] fail;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        start1, abort1, dut_y1;
  logic [3:0]  abcd1;
  logic        exp1, busy1, done1, valid1, pass1;
  logic [4:0]  err1;
  logic [15:0] fail1;

  logic        start3, abort3, dut_y3;
  logic [3:0]  abcd3;
  logic        exp3, busy3, done3, valid3, pass3;
  logic [4:0]  err3;
  logic [15:0] fail3;

  int   mode1;
  int   n_pass;
  int   n_fail;
  int   n_total;
  exp_t sb[$];

  sop_sweep_ctrl #(.SETTLE_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .dut_y(dut_y1),
    .abcd(abcd1), .exp_y(exp1), .busy(busy1), .done(done1), .valid(valid1),
    .err_count(err1), .fail_vec(fail1), .pass(pass1)
  );

  sop_sweep_ctrl #(.SETTLE_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .dut_y(dut_y3),
    .abcd(abcd3), .exp_y(exp3), .busy(busy3), .done(done3), .valid(valid3),
    .err_count(err3), .fail_vec(fail3), .pass(pass3)
  );

  always #5 clk = ~clk;

  // Reference function from the truth-table mask 0x7310.
  function automatic logic sop_ref(input logic [3:0] v);
    logic [15:0] m;
    m = 16'h7310;
    return m[v];
  endfunction

  // Function-under-test models: 0 golden, 1 stuck-0, 2 stuck-1, 3 fault on vector 7.
  function automatic logic drive_y(input int mode, input logic [3:0] v);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return sop_ref(v) ^ (v == 4'd7);
      default: return sop_ref(v);
    endcase
  endfunction

  function automatic exp_t predict(input int mode);
    exp_t e;
    e = '0;
    for (int k = 0; k < 16; k++) begin
      if (drive_y(mode, 4'(k)) != sop_ref(4'(k))) begin
        e.fail[k] = 1'b1;
        e.err     = e.err + 5'd1;
      end
    end
    return e;
  endfunction

  always_comb dut_y1 = drive_y(mode1, abcd1);
  always_comb dut_y3 = drive_y(0, abcd3);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_sweep(input int mode, input int glitch_at, input string tag);
    exp_t e;
    int   cycles;
    int   expm;
    bit   got;
    mode1  = mode;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    sb.push_back(predict(mode));
    check({tag, " busy_after_start"}, busy1, 1);
    check({tag, " abcd_after_start"}, abcd1, 0);
    check({tag, " valid_cleared"}, valid1, 0);
    cycles = 0;
    expm   = 0;
    got    = 0;
    while (cycles < 100) begin
      if (exp1 !== sop_ref(abcd1)) expm++;
      if (cycles == glitch_at) start1 = 1'b1;
      tick();
      start1 = 1'b0;
      cycles++;
      if (done1) begin
        got = 1;
        break;
      end
    end
    check({tag, " done_latency"}, got ? cycles : -1, 32);
    check({tag, " exp_y_errors"}, expm, 0);
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, " err_count"}, err1, e.err);
      check({tag, " fail_vec"}, fail1, e.fail);
      check({tag, " busy_at_done"}, busy1, 0);
      tick();
      check({tag, " done_one_cycle"}, done1, 0);
      check({tag, " valid"}, valid1, 1);
      check({tag, " pass"}, pass1, (e.err == 5'd0));
      check({tag, " abcd_after_done"}, abcd1, 0);
      check({tag, " err_hold"}, err1, e.err);
    end
  endtask

  initial begin
    int seen;
    int cycles;
    int run;
    int bad;
    int changes;
    bit got;
    logic [3:0] prev;

    clk = 0; rst_n = 1;
    start1 = 0; abort1 = 0; start3 = 0; abort3 = 0;
    mode1 = 0; n_pass = 0; n_fail = 0; n_total = 0;

    // Asynchronous reset between edges.
    #2 rst_n = 0;
    #1;
    check("rst abcd", abcd1, 0);
    check("rst busy", busy1, 0);
    check("rst done", done1, 0);
    check("rst valid", valid1, 0);
    check("rst err_count", err1, 0);
    check("rst fail_vec", fail1, 0);
    check("rst pass", pass1, 0);
    check("rst busy3", busy3, 0);
    tick();
    rst_n = 1;
    seen = 0;
    repeat (3) begin
      tick();
      if (done1 || busy1 || valid1) seen++;
    end
    check("idle_after_release", seen, 0);

    // Reset in the middle of a sweep, applied away from the clock edge.
    start1 = 1;
    tick();
    start1 = 0;
    repeat (5) tick();
    check("midsweep busy", busy1, 1);
    #3 rst_n = 0;
    #1;
    check("midsweep rst busy", busy1, 0);
    check("midsweep rst abcd", abcd1, 0);
    check("midsweep rst err", err1, 0);
    tick();
    rst_n = 1;
    seen = 0;
    repeat (40) begin
      tick();
      if (done1 || busy1) seen++;
    end
    check("no_done_after_reset", seen, 0);

    run_sweep(0, -1, "golden");
    run_sweep(1, -1, "stuck0");
    run_sweep(2, -1, "stuck1");
    run_sweep(3, -1, "vec7");
    run_sweep(0, 10, "start_glitch");

    // Abort while sampling vector 5 with errors already accumulated.
    mode1  = 2;
    start1 = 1;
    tick();
    start1 = 0;
    repeat (11) tick();
    check("abort pre abcd", abcd1, 5);
    check("abort pre err", err1, 4);
    abort1 = 1;
    tick();
    abort1 = 0;
    check("abort busy", busy1, 0);
    check("abort abcd", abcd1, 0);
    check("abort valid", valid1, 0);
    check("abort err", err1, 0);
    check("abort fail_vec", fail1, 0);
    seen = 0;
    repeat (40) begin
      if (done1) seen++;
      tick();
    end
    check("abort no_done", seen, 0);
    run_sweep(0, -1, "post_abort");

    abort1 = 1;
    tick();
    abort1 = 0;
    check("abort_idle valid", valid1, 1);
    check("abort_idle pass", pass1, 1);

    // Longer settle: latency and per-vector hold time.
    start3 = 1;
    tick();
    start3 = 0;
    cycles = 0; got = 0; bad = 0; changes = 0; run = 0;
    prev = abcd3;
    while (cycles < 200) begin
      if (abcd3 == prev) begin
        run++;
      end else begin
        if (run != 4) bad++;
        changes++;
        prev = abcd3;
        run = 1;
      end
      tick();
      cycles++;
      if (done3) begin
        got = 1;
        break;
      end
    end
    if (run != 4) bad++;
    check("settle3 done_latency", got ? cycles : -1, 64);
    check("settle3 hold_runs_bad", bad, 0);
    check("settle3 vector_steps", changes, 15);
    check("settle3 err_count", err3, 0);
    check("settle3 fail_vec", fail3, 0);
    tick();
    check("settle3 pass", pass3, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sop_sweep_ctrl.md
SOP_SWEEP_CTRL -- requirements
Module: sop_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 1, number of settle cycles per applied vector; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  sweep request; sampled in IDLE only.
REQ-005 abort  input  1  synchronous sweep cancel; sampled in SETTLE and SAMPLE.
REQ-006 dut_y  input  1  output of the 4-input SOP function under test; sampled in SAMPLE only.
REQ-007 abcd  output  4  registered stimulus: abcd[3]=a, abcd[2]=b, abcd[1]=c, abcd[0]=d.
REQ-008 exp_y  output  1  combinational expected value: (a&~c)|(b&~c&~d)|(a&b&~d), taken from abcd.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 valid  output  1  results hold a completed sweep.
REQ-012 err_count  output  5  number of mismatching vectors, 0..16.
REQ-013 fail_vec  output  16  bit k set when vector abcd=k mismatched.
REQ-014 pass  output  1  valid & (err_count==0).

Function
REQ-015 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE with start=1: abcd<=0, err_count<=0, fail_vec<=0, valid<=0, settle counter loaded, next state SETTLE.
REQ-017 SETTLE lasts exactly SETTLE_CYC cycles; abcd is held stable; the next state is SAMPLE.
REQ-018 SAMPLE lasts 1 cycle; when dut_y!=exp_y: err_count+1 and fail_vec[abcd] set.
REQ-019 SAMPLE with abcd!=15: abcd+1, counter reloaded, next state SETTLE.
REQ-020 SAMPLE with abcd==15: abcd holds 15, next state DONE; no wrap to 0 inside a sweep.
REQ-021 DONE lasts 1 cycle: done=1, valid<=1, next state IDLE; abcd<=0 on exit.
REQ-022 busy=1 exactly in SETTLE and SAMPLE.
REQ-023 Latency: done is high 16*(SETTLE_CYC+1) cycles after the start-accepting edge (32 at default).
REQ-024 start in any state other than IDLE is ignored; start held high in IDLE after DONE starts a new sweep.
REQ-025 abort in SETTLE or SAMPLE: next state IDLE, abcd<=0, valid<=0, err_count<=0, fail_vec<=0, no done pulse, and the current sample is discarded.
REQ-026 abort has priority over sample accumulation in the same cycle; abort in IDLE or DONE is ignored.
REQ-027 err_count, fail_vec and valid hold their values in IDLE until the next start or abort.
REQ-028 Expected truth-table mask is 0x7310 (minterms 4, 8, 9, 12, 13, 14).

Reset
REQ-029 rst_n=0 forces immediately, regardless of clk: state IDLE, abcd=0, busy=0, done=0, valid=0, err_count=0, fail_vec=0, pass=0.
REQ-030 Reset asserted mid-sweep abandons the sweep; no done follows reset release.
REQ-031 After rst_n deasserts, the first start is accepted on the next rising edge.

Verification
REQ-032 Reset check: assert rst_n=0 between edges -> all outputs 0 immediately; outputs stay 0 after release with no start.
REQ-033 Golden DUT: dut_y=exp_y-equivalent SOP, SETTLE_CYC=1, one-cycle start pulse -> done 32 cycles later, err_count=0, fail_vec=0x0000, pass=1, valid=1.
REQ-034 Stuck-at-0: dut_y=0 -> err_count=6, fail_vec=0x7310, pass=0.
REQ-035 Stuck-at-1: dut_y=1 -> err_count=10, fail_vec=0x8CEF, pass=0.
REQ-036 Abort at abcd=5 (SAMPLE) -> next cycle busy=0, abcd=0, valid=0, err_count=0, no done pulse; a new start gives a full 32-cycle sweep.
REQ-037 Robustness: start pulsed during busy does not change the done timing; SETTLE_CYC=3 gives done 64 cycles after start; abcd is stable for 4 cycles per vector.
